// File: rtl/apb_burst_scheduler.sv
// Burst-level APB port scheduler: weighted round-robin between the head write
// and head read bursts, holding the grant for one whole AXI burst.
module apb_burst_scheduler #(
  parameter int unsigned WR_WEIGHT = 1
) (
  input  logic       a_clk,
  input  logic       a_resetn,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [3:0] wr_len,
  input  logic [3:0] rd_len,
  input  logic       beat_done,
  input  logic       abort,
  output logic       gnt_wr,
  output logic       gnt_rd,
  output logic [3:0] beat_cnt,
  output logic       last_beat,
  output logic       burst_done,
  output logic       proto_err
);

  localparam int unsigned LEN_W = 4;
  localparam logic [LEN_W-1:0] WEIGHT = LEN_W'(WR_WEIGHT);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wr_streak;
  logic             last_gnt_wr;
  logic             granted;
  logic             pick_wr;

  assign granted    = (state != IDLE);
  assign gnt_wr     = (state == WR);
  assign gnt_rd     = (state == RD);
  assign last_beat  = granted & (beat_cnt == len_q);
  assign burst_done = granted & ((beat_done & last_beat) | abort);

  // Write wins when uncontended, right after a read, or while its streak is below weight.
  assign pick_wr = wr_req & (~rd_req | ~last_gnt_wr | (wr_streak < WEIGHT));

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state       <= IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      wr_streak   <= '0;
      last_gnt_wr <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat_done) proto_err <= 1'b1;
          if (pick_wr) begin
            state       <= WR;
            len_q       <= wr_len;
            beat_cnt    <= '0;
            last_gnt_wr <= 1'b1;
            if (!rd_req)                wr_streak <= '0;
            else if (wr_streak < WEIGHT) wr_streak <= wr_streak + LEN_W'(1);
          end else if (rd_req) begin
            state       <= RD;
            len_q       <= rd_len;
            beat_cnt    <= '0;
            last_gnt_wr <= 1'b0;
            wr_streak   <= '0;
          end
        end
        WR, RD: begin
          // Completion (last beat or abort) leaves beat_cnt frozen; it never wraps.
          if (burst_done)     state    <= IDLE;
          else if (beat_done) beat_cnt <= beat_cnt + LEN_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_burst_scheduler.sv
// Directed bench for apb_burst_scheduler: single burst, weighted arbitration,
// abort, protocol error and mid-burst reset.
module tb_apb_burst_scheduler;

  logic       a_clk = 1'b0;
  logic       a_resetn;
  logic       wr_req, rd_req, beat_done, abort;
  logic [3:0] wr_len, rd_len;

  logic       gnt_wr1, gnt_rd1, last_beat1, burst_done1, proto_err1;
  logic [3:0] beat_cnt1;
  logic       gnt_wr3, gnt_rd3, last_beat3, burst_done3, proto_err3;
  logic [3:0] beat_cnt3;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  always #5 a_clk = ~a_clk;

  apb_burst_scheduler #(.WR_WEIGHT(1)) dut1 (
    .a_clk(a_clk), .a_resetn(a_resetn), .wr_req(wr_req), .rd_req(rd_req),
    .wr_len(wr_len), .rd_len(rd_len), .beat_done(beat_done), .abort(abort),
    .gnt_wr(gnt_wr1), .gnt_rd(gnt_rd1), .beat_cnt(beat_cnt1),
    .last_beat(last_beat1), .burst_done(burst_done1), .proto_err(proto_err1)
  );

  apb_burst_scheduler #(.WR_WEIGHT(3)) dut3 (
    .a_clk(a_clk), .a_resetn(a_resetn), .wr_req(wr_req), .rd_req(rd_req),
    .wr_len(wr_len), .rd_len(rd_len), .beat_done(beat_done), .abort(abort),
    .gnt_wr(gnt_wr3), .gnt_rd(gnt_rd3), .beat_cnt(beat_cnt3),
    .last_beat(last_beat3), .burst_done(burst_done3), .proto_err(proto_err3)
  );

  // FIFO pop counter for the weight-1 instance
  always @(posedge a_clk) if (a_resetn && burst_done1) pops = pops + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge a_clk);
  endtask

  task automatic do_reset();
    a_resetn = 1'b0;
    wr_req = 0; rd_req = 0; beat_done = 0; abort = 0; wr_len = 0; rd_len = 0;
    tick(); tick();
    a_resetn = 1'b1;
    pops = 0;
  endtask

  initial begin : main
    logic exp_w1 [8];
    logic exp_w3 [8];
    logic got_w1 [$];
    logic got_w3 [$];
    int   gcycles;
    int   prev_gnt;

    exp_w1 = '{1, 0, 1, 0, 1, 0, 1, 0};
    exp_w3 = '{1, 1, 1, 0, 1, 1, 1, 0};

    // Reset state
    a_resetn = 1'b0;
    wr_req = 0; rd_req = 0; beat_done = 0; abort = 0; wr_len = 0; rd_len = 0;
    tick(); #1;
    check("rst_gnt_wr", gnt_wr1, 0);
    check("rst_gnt_rd", gnt_rd1, 0);
    check("rst_beat_cnt", beat_cnt1, 0);
    check("rst_last_beat", last_beat1, 0);
    check("rst_burst_done", burst_done1, 0);
    check("rst_proto_err", proto_err1, 0);
    do_reset();

    // Single write burst, len 3, zero-wait beats
    wr_req = 1; wr_len = 4'd3;
    #1 check("wr_gnt_latency", gnt_wr1, 0);
    gcycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_req = 0; wr_len = 4'd0; beat_done = 0;
      #1;
      if (gnt_wr1) gcycles++;
      check($sformatf("wr_beat_cnt%0d", i), beat_cnt1, i);
      tick();
      beat_done = 1;
      #1;
      if (gnt_wr1) gcycles++;
      check($sformatf("wr_last_beat%0d", i), last_beat1, (i == 3));
      check($sformatf("wr_burst_done%0d", i), burst_done1, (i == 3));
    end
    tick(); beat_done = 0; #1;
    check("wr_gnt_drop", gnt_wr1, 0);
    check("wr_gnt_cycles", gcycles, 8);
    check("wr_pops", pops, 1);

    // Weighted arbitration, both requests held, len 0
    do_reset();
    wr_req = 1; rd_req = 1;
    prev_gnt = 0;
    for (int c = 0; c < 40 && got_w1.size() < 8; c++) begin
      tick(); #1;
      if (gnt_wr1 | gnt_rd1) begin
        check("arb_excl", gnt_wr1 & gnt_rd1, 0);
        check("arb_gap", prev_gnt, 0);
        got_w1.push_back(gnt_wr1);
        got_w3.push_back(gnt_wr3);
      end
      prev_gnt = gnt_wr1 | gnt_rd1;
      beat_done = gnt_wr1 | gnt_rd1;
    end
    check("arb_grants", got_w1.size(), 8);
    for (int k = 0; k < 8 && k < got_w1.size(); k++) begin
      check($sformatf("w1_grant%0d", k), got_w1[k], exp_w1[k]);
      check($sformatf("w3_grant%0d", k), got_w3[k], exp_w3[k]);
    end
    check("arb_no_proto_err", proto_err1, 0);

    // Read burst len 7 aborted at beat 2 together with beat_done
    do_reset();
    rd_req = 1; rd_len = 4'd7;
    tick(); rd_req = 0; rd_len = 4'd0; #1;
    check("ab_gnt_rd", gnt_rd1, 1);
    for (int i = 0; i < 2; i++) begin
      beat_done = 1; tick(); beat_done = 0; tick();
    end
    #1;
    check("ab_beat_cnt", beat_cnt1, 2);
    check("ab_last_beat", last_beat1, 0);
    abort = 1; beat_done = 1;
    #1 check("ab_burst_done", burst_done1, 1);
    tick(); abort = 0; beat_done = 0; #1;
    check("ab_gnt_drop", gnt_rd1, 0);
    check("ab_beat_hold", beat_cnt1, 2);
    check("ab_pops", pops, 1);

    // beat_done in IDLE sets sticky proto_err
    beat_done = 1;
    tick(); beat_done = 0; #1;
    check("pe_set", proto_err1, 1);
    check("pe_beat_cnt", beat_cnt1, 2);
    wr_req = 1; wr_len = 4'd0;
    tick(); wr_req = 0; beat_done = 1; #1;
    check("pe_gnt_wr", gnt_wr1, 1);
    check("pe_burst_done", burst_done1, 1);
    tick(); beat_done = 0; #1;
    check("pe_sticky", proto_err1, 1);

    // Reset mid-burst at beat 5
    do_reset();
    #1 check("mr_pe_clear", proto_err1, 0);
    wr_req = 1; wr_len = 4'd9;
    tick(); wr_req = 0;
    for (int i = 0; i < 5; i++) begin
      beat_done = 1; tick(); beat_done = 0; tick();
    end
    #1;
    check("mr_beat5", beat_cnt1, 5);
    check("mr_gnt_before", gnt_wr1, 1);
    a_resetn = 0;
    #1;
    check("mr_gnt_async", gnt_wr1, 0);
    check("mr_cnt_async", beat_cnt1, 0);
    check("mr_no_done", burst_done1, 0);
    wr_req = 1; rd_req = 1;
    tick(); a_resetn = 1;
    tick(); #1;
    check("mr_pops", pops, 0);
    check("mr_first_wr", gnt_wr1, 1);
    check("mr_first_wr_w3", gnt_wr3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
